// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32 opcode / ALU-op / immediate-select encodings, the control bundle,
// and the decode and immediate-generation helpers shared by decode_stage.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ALU ops: {2'b00, alt, funct3} for arithmetic, {3'b010, funct3} for branch compares.
    localparam logic [5:0] ALU_ADD    = 6'h00;
    localparam logic [5:0] ALU_PASSB  = 6'h20;
    localparam logic [2:0] ALU_BR_CLS = 3'b010;

    typedef enum logic [2:0] {IMM_Z, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef struct packed {
        logic       rd_we;
        logic       res_src;
        logic       branch;
        logic       jump;
        logic       mem_we;
        logic       alu_src;
        logic [5:0] alu_op;
        imm_sel_e   imm_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{rd_we: 1'b0, res_src: 1'b0, branch: 1'b0, jump: 1'b0,
                                   mem_we: 1'b0, alu_src: 1'b0, alu_op: ALU_ADD, imm_sel: IMM_Z};

    function automatic ctrl_t decode_ctrl(input logic [31:0] ins);
        ctrl_t      c;
        logic [2:0] f3;
        f3 = ins[14:12];
        c  = CTRL_NOP;
        case (ins[6:0])
            OP_REG:    begin c.rd_we = 1'b1; c.alu_op = {2'b00, ins[30], f3}; end
            // Only SRAI uses bit 30 as an opcode bit; elsewhere it is immediate.
            OP_IMM:    begin c.rd_we = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_I;
                             c.alu_op = {2'b00, (f3 == 3'b101) & ins[30], f3}; end
            OP_LOAD:   begin c.rd_we = 1'b1; c.res_src = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_I; end
            OP_STORE:  begin c.mem_we = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_S; end
            OP_BRANCH: begin c.branch = 1'b1; c.imm_sel = IMM_B; c.alu_op = {ALU_BR_CLS, f3}; end
            OP_JAL:    begin c.rd_we = 1'b1; c.jump = 1'b1; c.imm_sel = IMM_J; end
            OP_JALR:   begin c.rd_we = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_I; end
            OP_LUI:    begin c.rd_we = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_U; c.alu_op = ALU_PASSB; end
            OP_AUIPC:  begin c.rd_we = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_U; end
            default:   c = CTRL_NOP;
        endcase
        return c;
    endfunction

    function automatic logic signed [31:0] imm_gen(input logic [31:0] ins, input imm_sel_e sel);
        logic signed [31:0] v;
        case (sel)
            IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   v = {ins[31:12], 12'b0};
            IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decode_stage_id_hazard_unit.sv
// id_hazard_unit: flags a load-use dependence between the load held in ID/EX and the
// source fields of the instruction currently presented to decode.
module id_hazard_unit #(
    parameter int AW = 5
) (
    input  logic          i_ex_valid,
    input  logic          i_ex_res_src,
    input  logic          i_ex_rd_we,
    input  logic [AW-1:0] i_ex_rd,
    input  logic [AW-1:0] i_id_rs1,
    input  logic [AW-1:0] i_id_rs2,
    output logic          o_hazard
);
    assign o_hazard = i_ex_valid && i_ex_res_src && i_ex_rd_we && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage with valid/ready handshake, regfile, flush and load-use bubbles.
// Define ID_WB_BYPASS_EN to make the register read ports write-first against writeback.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              ALU_OP_W = 6,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     next_pc_in,
    input  logic                flush,
    input  logic                ex_ready,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                out_valid,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     next_pc_out,
    output logic                rd_write_enable,
    output logic                res_src,
    output logic                branch,
    output logic                jump,
    output logic                mem_write_enable,
    output logic                alu_input_conf,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic [AW-1:0]       rd_write_addr,
    output logic [AW-1:0]       rs1_addr,
    output logic [AW-1:0]       rs2_addr
);
    logic [AW-1:0]       w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]     w_rs1_data, w_rs2_data, w_imm;
    ctrl_t               w_ctrl;
    logic                w_hazard, w_advance, w_accept;

    logic [XLEN-1:0]     r_regs [NREGS];
    logic                r_vld_p1, r_rd_we_p1, r_res_src_p1, r_branch_p1, r_jump_p1;
    logic                r_mem_we_p1, r_alu_src_p1;
    logic [ALU_OP_W-1:0] r_alu_op_p1;
    logic [XLEN-1:0]     r_pc_p1, r_npc_p1, r_imm_p1, r_rs1_data_p1, r_rs2_data_p1;
    logic [AW-1:0]       r_rd_p1, r_rs1_p1, r_rs2_p1;

    assign w_rs1  = AW'(instr[19:15]);
    assign w_rs2  = AW'(instr[24:20]);
    assign w_rd   = AW'(instr[11:7]);
    assign w_ctrl = decode_ctrl(instr);
    assign w_imm  = XLEN'(imm_gen(instr, w_ctrl.imm_sel));

`ifdef ID_WB_BYPASS_EN
    assign w_rs1_data = (w_rs1 == '0) ? '0 : (wb_we && wb_addr == w_rs1) ? wb_data : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 : (wb_we && wb_addr == w_rs2) ? wb_data : r_regs[w_rs2];
`else
    assign w_rs1_data = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    id_hazard_unit #(.AW(AW)) u_hazard (
        .i_ex_valid   (r_vld_p1),
        .i_ex_res_src (r_res_src_p1),
        .i_ex_rd_we   (r_rd_we_p1),
        .i_ex_rd      (r_rd_p1),
        .i_id_rs1     (w_rs1),
        .i_id_rs2     (w_rs2),
        .o_hazard     (w_hazard)
    );

    assign w_advance = !r_vld_p1 || ex_ready;
    assign in_ready  = w_advance && !w_hazard && !flush;
    assign w_accept  = in_valid && in_ready;

    // ID/EX boundary: flush or an advancing cycle without accept inserts a bubble; stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1      <= 1'b0;
            r_rd_we_p1    <= 1'b0;
            r_res_src_p1  <= 1'b0;
            r_branch_p1   <= 1'b0;
            r_jump_p1     <= 1'b0;
            r_mem_we_p1   <= 1'b0;
            r_alu_src_p1  <= 1'b0;
            r_alu_op_p1   <= '0;
            r_pc_p1       <= RESET_PC;
            r_npc_p1      <= RESET_PC;
            r_imm_p1      <= '0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_rd_p1       <= '0;
            r_rs1_p1      <= '0;
            r_rs2_p1      <= '0;
        end else if (flush || (w_advance && !w_accept)) begin
            r_vld_p1     <= 1'b0;
            r_rd_we_p1   <= 1'b0;
            r_res_src_p1 <= 1'b0;
            r_branch_p1  <= 1'b0;
            r_jump_p1    <= 1'b0;
            r_mem_we_p1  <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1      <= 1'b1;
            r_rd_we_p1    <= w_ctrl.rd_we;
            r_res_src_p1  <= w_ctrl.res_src;
            r_branch_p1   <= w_ctrl.branch;
            r_jump_p1     <= w_ctrl.jump;
            r_mem_we_p1   <= w_ctrl.mem_we;
            r_alu_src_p1  <= w_ctrl.alu_src;
            r_alu_op_p1   <= ALU_OP_W'(w_ctrl.alu_op);
            r_pc_p1       <= pc_in;
            r_npc_p1      <= next_pc_in;
            r_imm_p1      <= w_imm;
            r_rs1_data_p1 <= w_rs1_data;
            r_rs2_data_p1 <= w_rs2_data;
            r_rd_p1       <= w_rd;
            r_rs1_p1      <= w_rs1;
            r_rs2_p1      <= w_rs2;
        end
    end

    assign out_valid        = r_vld_p1;
    assign pc_out           = r_pc_p1;
    assign next_pc_out      = r_npc_p1;
    assign rd_write_enable  = r_rd_we_p1;
    assign res_src          = r_res_src_p1;
    assign branch           = r_branch_p1;
    assign jump             = r_jump_p1;
    assign mem_write_enable = r_mem_we_p1;
    assign alu_input_conf   = r_alu_src_p1;
    assign alu_op           = r_alu_op_p1;
    assign imm              = r_imm_p1;
    assign rs1_data         = r_rs1_data_p1;
    assign rs2_data         = r_rs2_data_p1;
    assign rd_write_addr    = r_rd_p1;
    assign rs1_addr         = r_rs1_p1;
    assign rs2_addr         = r_rs2_p1;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus a randomized stream for decode_stage, checked
// against a transaction-level model built from instruction descriptors and the handshake rules.
`timescale 1ns/1ps
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_e;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc, npc;
        logic        rd_we, res_src, branch, jump, mem_we, alu_src;
        logic [5:0]  alu_op;
        logic [31:0] imm, rs1d, rs2d;
        logic [4:0]  rd, rs1, rs2;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, ex_ready, wb_we;
    logic [31:0] instr, pc_in, next_pc_in, wb_data;
    logic [4:0]  wb_addr;
    logic        out_valid, rd_write_enable, res_src, branch, jump, mem_write_enable, alu_input_conf;
    logic [31:0] pc_out, next_pc_out, imm, rs1_data, rs2_data;
    logic [5:0]  alu_op;
    logic [4:0]  rd_write_addr, rs1_addr, rs2_addr;

    out_t        m;
    out_t        cur_f;
    logic [31:0] m_regs [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NREGS(32), .ALU_OP_W(6), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .rd_write_enable(rd_write_enable),
        .res_src(res_src), .branch(branch), .jump(jump), .mem_write_enable(mem_write_enable),
        .alu_input_conf(alu_input_conf), .alu_op(alu_op), .imm(imm), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .rd_write_addr(rd_write_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr)
    );

    function automatic out_t got();
        out_t o;
        o.vld = out_valid; o.pc = pc_out; o.npc = next_pc_out;
        o.rd_we = rd_write_enable; o.res_src = res_src; o.branch = branch; o.jump = jump;
        o.mem_we = mem_write_enable; o.alu_src = alu_input_conf; o.alu_op = alu_op;
        o.imm = imm; o.rs1d = rs1_data; o.rs2d = rs2_data;
        o.rd = rd_write_addr; o.rs1 = rs1_addr; o.rs2 = rs2_addr;
        return o;
    endfunction

    // Bubbles only promise a clear valid and clear side-effect enables.
    function automatic out_t view(input out_t o, input logic full);
        out_t r;
        if (full) return o;
        r = '0;
        r.vld = o.vld; r.rd_we = o.rd_we; r.mem_we = o.mem_we; r.branch = o.branch; r.jump = o.jump;
        return r;
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_hazard();
        return m.vld && m.res_src && m.rd_we && m.rd != 5'd0 &&
               (m.rd == instr[19:15] || m.rd == instr[24:20]);
    endfunction

    function automatic logic model_ready();
        return (!m.vld || ex_ready) && !model_hazard() && !flush;
    endfunction

    task automatic model_reset();
        m = '0; m.pc = RESET_PC; m.npc = RESET_PC;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // Encode an instruction from its fields and record what decode should produce for it.
    task automatic set_instr(input kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3, input logic f7b, input int immv);
        logic [31:0] v;
        v = 32'(immv);
        cur_f = '0;
        cur_f.imm = v;
        case (k)
            K_R:     begin instr = {(f7b ? 7'h20 : 7'h00), rs2, rs1, f3, rd, OP_REG};
                           cur_f.rd_we = 1; cur_f.alu_op = {2'b00, f7b, f3}; cur_f.imm = 0; end
            K_I:     begin instr = {v[11:0], rs1, f3, rd, OP_IMM}; cur_f.rd_we = 1; cur_f.alu_src = 1;
                           cur_f.alu_op = {2'b00, (f3 == 3'd5) ? v[10] : 1'b0, f3}; end
            K_LOAD:  begin instr = {v[11:0], rs1, 3'b010, rd, OP_LOAD};
                           cur_f.rd_we = 1; cur_f.res_src = 1; cur_f.alu_src = 1; end
            K_STORE: begin instr = {v[11:5], rs2, rs1, 3'b010, v[4:0], OP_STORE};
                           cur_f.mem_we = 1; cur_f.alu_src = 1; end
            K_BR:    begin instr = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], OP_BRANCH};
                           cur_f.branch = 1; cur_f.alu_op = {3'b010, f3}; end
            K_JAL:   begin instr = {v[20], v[10:1], v[11], v[19:12], rd, OP_JAL};
                           cur_f.rd_we = 1; cur_f.jump = 1; end
            K_JALR:  begin instr = {v[11:0], rs1, 3'b000, rd, OP_JALR};
                           cur_f.rd_we = 1; cur_f.jump = 1; cur_f.alu_src = 1; end
            K_LUI:   begin instr = {v[31:12], rd, OP_LUI}; cur_f.rd_we = 1; cur_f.alu_src = 1;
                           cur_f.alu_op = ALU_PASSB; end
            K_AUIPC: begin instr = {v[31:12], rd, OP_AUIPC}; cur_f.rd_we = 1; cur_f.alu_src = 1; end
            default: begin instr = {v[31:7], 7'h7F}; cur_f.imm = 0; end
        endcase
        cur_f.rd = instr[11:7]; cur_f.rs1 = instr[19:15]; cur_f.rs2 = instr[24:20];
        pc_in = $urandom & 32'hFFFF_FFFC;
        next_pc_in = pc_in + 32'd4;
    endtask

    task automatic rand_instr();
        kind_e      k;
        int         iv;
        logic [2:0] f3;
        k  = kind_e'($urandom_range(0, 9));
        f3 = 3'($urandom_range(0, 7));
        case (k)
            K_I:     if (f3 == 3'd1 || f3 == 3'd5)
                         iv = int'($urandom_range(0, 31)) + ((f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 1024 : 0);
                     else iv = int'($urandom_range(0, 4095)) - 2048;
            K_LOAD, K_STORE, K_JALR: iv = int'($urandom_range(0, 4095)) - 2048;
            K_BR:    iv = (int'($urandom_range(0, 4095)) - 2048) * 2;
            K_JAL:   iv = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            K_LUI, K_AUIPC: iv = int'($urandom & 32'hFFFF_F000);
            default: iv = int'($urandom);
        endcase
        set_instr(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  f3, 1'($urandom_range(0, 1)), iv);
    endtask

    // Advance one clock, moving the model through flush > hold > hazard > accept > bubble.
    task automatic cycle();
        out_t nxt;
        nxt = m;
        if (flush) begin
            nxt.vld = 0; nxt.rd_we = 0; nxt.mem_we = 0; nxt.branch = 0; nxt.jump = 0;
        end else if (m.vld && !ex_ready) begin
            nxt = m;
        end else if (model_hazard() || !in_valid) begin
            nxt.vld = 0; nxt.rd_we = 0; nxt.mem_we = 0; nxt.branch = 0; nxt.jump = 0;
        end else begin
            nxt = cur_f; nxt.vld = 1; nxt.pc = pc_in; nxt.npc = next_pc_in;
            nxt.rs1d = read_reg(instr[19:15]); nxt.rs2d = read_reg(instr[24:20]);
        end
        if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; ex_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); set_instr(K_BAD, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got() !== m) begin errors++; $display("FAIL reset_state got=%h exp=%h", got(), m); end
        rst_n = 1;
    endtask

    task automatic test_addi();
        idle_inputs(); in_valid = 1;
        set_instr(K_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 5);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_ready got=%b exp=1", in_ready); end
        cycle();
        in_valid = 0;
        checks++;
        if ({out_valid, imm, rd_write_addr, alu_input_conf} !== {1'b1, 32'd5, 5'd1, 1'b1}) begin
            errors++; $display("FAIL addi_fields got=%b/%h/%0d/%b exp=1/00000005/1/1",
                               out_valid, imm, rd_write_addr, alu_input_conf);
        end
        checks++;
        if (got() !== m) begin errors++; $display("FAIL addi_model got=%h exp=%h", got(), m); end
    endtask

    task automatic test_load_use();
        idle_inputs(); wb_we = 1; wb_addr = 5'd1; wb_data = 32'h0000_0400;
        cycle();
        idle_inputs(); in_valid = 1;
        set_instr(K_LOAD, 5'd2, 5'd1, 5'd0, 3'd2, 1'b0, 0);
        cycle();
        checks++;
        if (got() !== m || m.rs1d !== 32'h0000_0400) begin
            errors++; $display("FAIL lw_issue got=%h exp=%h", got(), m);
        end
        set_instr(K_R, 5'd3, 5'd2, 5'd2, 3'd0, 1'b0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_stall got=%b exp=0", in_ready); end
        cycle();
        checks++;
        if ({out_valid, rd_write_enable, mem_write_enable} !== 3'b000) begin
            errors++; $display("FAIL loaduse_bubble got=%b exp=000", {out_valid, rd_write_enable, mem_write_enable});
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_release got=%b exp=1", in_ready); end
        cycle();
        in_valid = 0;
        checks++;
        if (got() !== m || {out_valid, rd_write_addr} !== {1'b1, 5'd3}) begin
            errors++; $display("FAIL add_after_bubble got=%h exp=%h", got(), m);
        end
    endtask

    task automatic test_hold();
        idle_inputs(); in_valid = 1;
        set_instr(K_R, 5'd4, 5'd1, 5'd0, 3'd0, 1'b1, 0);
        cycle();
        ex_ready = 0;
        set_instr(K_STORE, 5'd0, 5'd1, 5'd4, 3'd2, 1'b0, -12);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, in_ready); end
            cycle();
            checks++;
            if (got() !== m || out_valid !== 1'b1 || rd_write_addr !== 5'd4) begin
                errors++; $display("FAIL hold_stable[%0d] got=%h exp=%h", i, got(), m);
            end
        end
        ex_ready = 1;
        cycle();
        in_valid = 0;
        checks++;
        if (got() !== m || {mem_write_enable, imm} !== {1'b1, 32'hFFFF_FFF4}) begin
            errors++; $display("FAIL hold_resume got=%h exp=%h", got(), m);
        end
    endtask

    task automatic test_flush();
        idle_inputs(); in_valid = 1;
        set_instr(K_LOAD, 5'd4, 5'd1, 5'd0, 3'd2, 1'b0, 8);
        cycle();
        set_instr(K_R, 5'd5, 5'd4, 5'd0, 3'd0, 1'b0, 0);
        flush = 1; ex_ready = 0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        cycle();
        checks++;
        if ({out_valid, rd_write_enable} !== 2'b00) begin
            errors++; $display("FAIL flush_kill got=%b exp=00", {out_valid, rd_write_enable});
        end
        flush = 0; in_valid = 0; ex_ready = 1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp5;
`ifdef ID_WB_BYPASS_EN
        exp5 = 32'h0000_DEAD;
`else
        exp5 = 32'h0000_1234;
`endif
        idle_inputs(); wb_we = 1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        cycle();
        in_valid = 1; wb_data = 32'h0000_DEAD;
        set_instr(K_R, 5'd6, 5'd0, 5'd5, 3'd0, 1'b0, 0);
        cycle();
        checks++;
        if (rs2_data !== exp5) begin errors++; $display("FAIL bypass_x5 got=%h exp=%h", rs2_data, exp5); end
        wb_addr = 5'd0; wb_data = 32'h0000_BEEF;
        set_instr(K_R, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 0);
        cycle();
        checks++;
        if (rs1_data !== 32'd0) begin errors++; $display("FAIL bypass_x0 got=%h exp=00000000", rs1_data); end
        wb_we = 0;
        set_instr(K_R, 5'd7, 5'd5, 5'd5, 3'd0, 1'b0, 0);
        cycle();
        in_valid = 0;
        checks++;
        if ({rs1_data, rs2_data} !== {32'h0000_DEAD, 32'h0000_DEAD} || got() !== m) begin
            errors++; $display("FAIL regfile_written got=%h/%h exp=0000dead/0000dead", rs1_data, rs2_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 99) < 75);
            ex_ready = ($urandom_range(0, 99) < 70);
            flush    = ($urandom_range(0, 99) < 8);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            rand_instr();
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, in_ready, model_ready());
            end
            cycle();
            checks++;
            if (view(got(), m.vld) !== view(m, m.vld)) begin
                errors++; $display("FAIL rand_out[%0d] got=%h exp=%h", n, view(got(), m.vld), view(m, m.vld));
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        idle_inputs(); wb_we = 1; wb_addr = 5'd5; wb_data = 32'h0000_0777;
        in_valid = 1;
        set_instr(K_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 2048);
        cycle();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({out_valid, pc_out, next_pc_out, jump} !== {1'b0, RESET_PC, RESET_PC, 1'b0}) begin
            errors++; $display("FAIL async_reset got=%b/%h/%h/%b exp=0/%h/%h/0",
                               out_valid, pc_out, next_pc_out, jump, RESET_PC, RESET_PC);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        in_valid = 1;
        set_instr(K_R, 5'd1, 5'd5, 5'd5, 3'd0, 1'b0, 0);
        cycle();
        in_valid = 0;
        checks++;
        if ({rs1_data, rs2_data} !== 64'd0 || got() !== m) begin
            errors++; $display("FAIL regfile_cleared got=%h/%h exp=0/0", rs1_data, rs2_data);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_hold();
        test_flush();
        test_bypass();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
